// File: rtl/fact_ctrl.sv
// Control unit for the iterative factorial datapath: accepts N on a GO/DONE
// handshake, range-checks it and sequences the counter/multiplier/accumulator strobes.
module fact_ctrl #(
  parameter int WIDTH = 32,
  parameter int MAX_N = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  input  logic [WIDTH-1:0] N_IN,
  input  logic             GT,
  output logic [WIDTH-1:0] N_OUT,
  output logic             MUX,
  output logic             REG_LD,
  output logic             CNT_LD,
  output logic             CNT_EN,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY,
  output logic [2:0]       STATE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [WIDTH-1:0] MAX_LIM = WIDTH'(MAX_N);

  // Handshake: GO is a level request sampled only in IDLE; DONE stays high in
  // FIN/ERR until GO is seen low, so one GO assertion yields exactly one run.
  logic [2:0] state;
  logic [2:0] state_nx;

  assign STATE = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // N is captured only on the accepting edge and held until the next acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      N_OUT <= '0;
    end else if (state == S_IDLE && GO) begin
      N_OUT <= N_IN;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE: begin
        if (!GO)                 state_nx = S_IDLE;
        else if (N_IN > MAX_LIM) state_nx = S_ERR;
        else                     state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = S_CHECK;
      S_CHECK: state_nx = GT ? S_MULT : S_FIN;
      S_MULT:  state_nx = S_CHECK;
      S_FIN:   state_nx = GO ? S_FIN : S_IDLE;
      S_ERR:   state_nx = GO ? S_ERR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    MUX    = 1'b0;
    REG_LD = 1'b0;
    CNT_LD = 1'b0;
    CNT_EN = 1'b0;
    DONE   = 1'b0;
    ERR    = 1'b0;
    BUSY   = 1'b0;
    case (state)
      S_LOAD: begin
        CNT_LD = 1'b1;
        REG_LD = 1'b1;
        BUSY   = 1'b1;
      end
      S_CHECK: BUSY = 1'b1;
      S_MULT: begin
        MUX    = 1'b1;
        REG_LD = 1'b1;
        CNT_EN = 1'b1;
        BUSY   = 1'b1;
      end
      S_FIN: begin
        DONE = 1'b1;
        BUSY = 1'b1;
      end
      S_ERR: begin
        DONE = 1'b1;
        ERR  = 1'b1;
        BUSY = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: a behavioural datapath closes the loop, and every run is
// compared with factorial/latency/pulse counts computed directly from N.
module tb_fact_ctrl;
  localparam int WIDTH = 32;
  localparam int MAX_N = 12;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_MULT = 3'd3,
                         ST_FIN = 3'd4, ST_ERR = 3'd5;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             GO = 1'b0;
  logic [WIDTH-1:0] N_IN = '0;
  logic             GT;
  logic [WIDTH-1:0] N_OUT;
  logic             MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY;
  logic [2:0]       STATE;

  int checks = 0;
  int errors = 0;

  fact_ctrl #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .N_IN(N_IN), .GT(GT), .N_OUT(N_OUT),
    .MUX(MUX), .REG_LD(REG_LD), .CNT_LD(CNT_LD), .CNT_EN(CNT_EN),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Datapath: down-counter, multiplier, 1/product mux, accumulator, gated output.
  logic [WIDTH-1:0] dp_cnt = '0;
  logic [WIDTH-1:0] dp_acc = '0;
  logic [WIDTH-1:0] dp_out;
  always @(posedge CLK) begin
    if (CNT_LD)      dp_cnt <= N_OUT;
    else if (CNT_EN) dp_cnt <= dp_cnt - 1;
    if (REG_LD)      dp_acc <= MUX ? dp_acc * dp_cnt : 32'd1;
  end
  assign GT     = (dp_cnt > 32'd1);
  assign dp_out = DONE ? dp_acc : '0;

  function automatic logic [WIDTH-1:0] ref_fact(input int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[WIDTH-1:0];
  endfunction

  task automatic run_one(input logic [WIDTH-1:0] n, input bit pulse,
                         input int hold_cycles, input string tag);
    bit               exp_err;
    int               exp_mult, exp_lat, lat, n_cnt_ld, n_reg_ld, n_cnt_en;
    logic [WIDTH-1:0] exp_res, acc_before;
    logic [2:0]       exp_state;
    bit               hold_ok;
    exp_err   = (n > WIDTH'(MAX_N));
    exp_mult  = (!exp_err && n > 1) ? int'(n) - 1 : 0;
    exp_lat   = exp_err ? 0 : 2 + 2 * exp_mult;
    exp_state = exp_err ? ST_ERR : ST_FIN;
    @(negedge CLK);
    acc_before = dp_acc;
    exp_res    = exp_err ? acc_before : ref_fact(int'(n));
    GO = 1'b1;
    N_IN = n;
    @(posedge CLK); #1;
    if (pulse) GO = 1'b0;
    lat = 0; n_cnt_ld = 0; n_reg_ld = 0; n_cnt_en = 0;
    while (STATE != ST_FIN && STATE != ST_ERR && lat < 100) begin
      n_cnt_ld += int'(CNT_LD); n_reg_ld += int'(REG_LD); n_cnt_en += int'(CNT_EN);
      N_IN = $urandom;
      @(posedge CLK); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", tag, lat, exp_lat);
    end
    checks++;
    if ({STATE, DONE, ERR, BUSY} !== {exp_state, 1'b1, exp_err, 1'b1}) begin
      errors++;
      $display("FAIL %s end_state got st=%0d done=%b err=%b busy=%b exp st=%0d done=1 err=%b busy=1",
               tag, STATE, DONE, ERR, BUSY, exp_state, exp_err);
    end
    checks++;
    if (dp_out !== exp_res) begin
      errors++; $display("FAIL %s result got %0d exp %0d", tag, dp_out, exp_res);
    end
    checks++;
    if (N_OUT !== n) begin
      errors++; $display("FAIL %s n_out got %0d exp %0d", tag, N_OUT, n);
    end
    hold_ok = 1'b1;
    n_cnt_ld += int'(CNT_LD); n_reg_ld += int'(REG_LD); n_cnt_en += int'(CNT_EN);
    for (int i = 0; i < hold_cycles; i++) begin
      N_IN = $urandom;
      @(posedge CLK); #1;
      n_cnt_ld += int'(CNT_LD); n_reg_ld += int'(REG_LD); n_cnt_en += int'(CNT_EN);
      if (STATE !== exp_state || DONE !== 1'b1) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++; $display("FAIL %s hold left state while GO high, now st=%0d", tag, STATE);
    end
    checks++;
    if (n_cnt_ld !== (exp_err ? 0 : 1) || n_reg_ld !== (exp_err ? 0 : exp_mult + 1) ||
        n_cnt_en !== exp_mult) begin
      errors++;
      $display("FAIL %s pulses got cnt_ld=%0d reg_ld=%0d cnt_en=%0d exp %0d %0d %0d", tag,
               n_cnt_ld, n_reg_ld, n_cnt_en, exp_err ? 0 : 1, exp_err ? 0 : exp_mult + 1, exp_mult);
    end
    @(negedge CLK);
    GO = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({STATE, DONE, BUSY} !== {ST_IDLE, 1'b0, 1'b0} || N_OUT !== n) begin
      errors++;
      $display("FAIL %s release got st=%0d done=%b busy=%b n_out=%0d exp st=0 done=0 busy=0 n_out=%0d",
               tag, STATE, DONE, BUSY, N_OUT, n);
    end
  endtask

  task automatic test_reset();
    GO = 1'b1;
    N_IN = 32'd5;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({STATE, N_OUT, MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY} !== 42'd0) begin
      errors++;
      $display("FAIL reset outputs got st=%0d n_out=%0d strobes=%b exp all 0", STATE, N_OUT,
               {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY});
    end
    @(negedge CLK);
    RST = 1'b0;
    GO = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (STATE !== ST_IDLE || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_release got st=%0d busy=%b exp st=0 busy=0", STATE, BUSY);
    end
  endtask

  task automatic test_basic();
    run_one(32'd5, 1'b1, 0, "n5");
    run_one(32'd0, 1'b1, 0, "n0");
    run_one(32'd1, 1'b1, 0, "n1");
  endtask

  task automatic test_range();
    run_one(32'd12, 1'b1, 0, "n12");
    run_one(32'd13, 1'b0, 3, "n13");
    run_one(32'h8000_0000, 1'b0, 2, "n_msb");
  endtask

  task automatic test_go_held();
    run_one(32'd3, 1'b0, 50, "go_held");
  endtask

  task automatic test_async_reset();
    int guard;
    @(negedge CLK);
    GO = 1'b1;
    N_IN = 32'd7;
    @(posedge CLK); #1;
    GO = 1'b0;
    guard = 0;
    while (STATE != ST_MULT && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    checks++;
    if (STATE !== ST_MULT) begin
      errors++; $display("FAIL areset_reach_mult got st=%0d exp st=%0d", STATE, ST_MULT);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({STATE, N_OUT, MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY} !== 42'd0) begin
      errors++;
      $display("FAIL areset_outputs got st=%0d n_out=%0d strobes=%b exp all 0", STATE, N_OUT,
               {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY});
    end
    @(negedge CLK);
    RST = 1'b0;
    run_one(32'd4, 1'b1, 0, "after_reset_n4");
  endtask

  task automatic test_illegal_state();
    logic [2:0] code;
    for (int c = 6; c < 8; c++) begin
      code = 3'(c);
      @(negedge CLK);
      force dut.state = code;
      #1;
      checks++;
      if (STATE !== code || {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY} !== 7'd0) begin
        errors++;
        $display("FAIL illegal_outputs got st=%0d strobes=%b exp st=%0d strobes=0", STATE,
                 {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY}, code);
      end
      #1;
      release dut.state;
      @(posedge CLK); #1;
      checks++;
      if (STATE !== ST_IDLE || {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY} !== 7'd0) begin
        errors++;
        $display("FAIL illegal_recover got st=%0d strobes=%b exp st=0 strobes=0", STATE,
                 {MUX, REG_LD, CNT_LD, CNT_EN, DONE, ERR, BUSY});
      end
    end
  endtask

  task automatic test_back_to_back();
    run_one(32'd3, 1'b0, 0, "b2b_n3");
    run_one(32'd6, 1'b0, 0, "b2b_n6");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] n;
    bit               pulse;
    repeat (16) begin
      n     = WIDTH'($urandom_range(0, 14));
      pulse = 1'($urandom_range(0, 1));
      run_one(n, pulse, pulse ? 0 : $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_go_held();
    test_async_reset();
    test_illegal_state();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
